// File: rtl/id_ex_stage_if.sv
// Signal bundle between the decode/hazard/forwarding sources and the ID/EX
// pipeline register. The master side drives the decode stage fields, the
// hazard controls and the MEM/WB forward sources; the slave side is the
// ID/EX stage, which returns the EX-stage operands and registered control.
interface id_ex_stage_if #(
  parameter int DATA_W = 32
);
  // Hazard controls
  logic              stall;
  logic              flush;
  // Decode stage fields
  logic              id_valid;
  logic [DATA_W-1:0] id_pc;
  logic [DATA_W-1:0] id_rd1;
  logic [DATA_W-1:0] id_rd2;
  logic [DATA_W-1:0] id_imm;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_writereg;
  logic [1:0]        id_aluop;
  logic [5:0]        id_funct;
  logic              id_alusrc;
  logic              id_regwrite;
  logic              id_memtoreg;
  logic              id_memwrite;
  // Forward sources
  logic              mem_regwrite;
  logic [4:0]        mem_writereg;
  logic [DATA_W-1:0] mem_result;
  logic              wb_regwrite;
  logic [4:0]        wb_writereg;
  logic [DATA_W-1:0] wb_result;
  // EX stage outputs
  logic              ex_valid;
  logic [DATA_W-1:0] ex_pc;
  logic [DATA_W-1:0] alu_num1;
  logic [DATA_W-1:0] alu_num2;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] ex_storedata;
  logic [4:0]        ex_writereg;
  logic              ex_regwrite;
  logic              ex_memtoreg;
  logic              ex_memwrite;
  logic              ex_illegal;

  modport master (
    output stall, flush,
    output id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_writereg,
    output id_aluop, id_funct, id_alusrc, id_regwrite, id_memtoreg, id_memwrite,
    output mem_regwrite, mem_writereg, mem_result,
    output wb_regwrite, wb_writereg, wb_result,
    input  ex_valid, ex_pc, alu_num1, alu_num2, alu_op, ex_storedata,
    input  ex_writereg, ex_regwrite, ex_memtoreg, ex_memwrite, ex_illegal
  );

  modport slave (
    input  stall, flush,
    input  id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_writereg,
    input  id_aluop, id_funct, id_alusrc, id_regwrite, id_memtoreg, id_memwrite,
    input  mem_regwrite, mem_writereg, mem_result,
    input  wb_regwrite, wb_writereg, wb_result,
    output ex_valid, ex_pc, alu_num1, alu_num2, alu_op, ex_storedata,
    output ex_writereg, ex_regwrite, ex_memtoreg, ex_memwrite, ex_illegal
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the five-stage MIPS core. Captures decoded
// operands and control, decodes the 3-bit ALU op at capture time, and
// resolves MEM/WB forwarding combinationally from the registered rs/rt so a
// stalled instruction keeps picking up fresh forward results.
module id_ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          resetn,
  id_ex_stage_if.slave  bus
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // Returns {illegal, alu_op}; unsupported R-type functs fall back to add.
  function automatic logic [3:0] decode_alu(input logic [1:0] aluop,
                                            input logic [5:0] funct);
    logic [3:0] res;
    res = {1'b0, OP_ADD};
    case (aluop)
      2'b00: res = {1'b0, OP_ADD};
      2'b01: res = {1'b0, OP_SUB};
      2'b11: res = {1'b0, OP_OR};
      default: begin
        case (funct)
          6'b100000: res = {1'b0, OP_ADD};
          6'b100010: res = {1'b0, OP_SUB};
          6'b100100: res = {1'b0, OP_AND};
          6'b100101: res = {1'b0, OP_OR};
          6'b101010: res = {1'b0, OP_SLT};
          default:   res = {1'b1, OP_ADD};
        endcase
      end
    endcase
    return res;
  endfunction

  // MEM beats WB; register 0 is hardwired and never forwarded.
  function automatic logic [DATA_W-1:0] forward(
    input logic [4:0]        src,
    input logic [DATA_W-1:0] regval,
    input logic              m_we,
    input logic [4:0]        m_reg,
    input logic [DATA_W-1:0] m_res,
    input logic              w_we,
    input logic [4:0]        w_reg,
    input logic [DATA_W-1:0] w_res
  );
    logic [DATA_W-1:0] val;
    val = regval;
    if (m_we && (m_reg != 5'd0) && (m_reg == src))
      val = m_res;
    else if (w_we && (w_reg != 5'd0) && (w_reg == src))
      val = w_res;
    return val;
  endfunction

  logic              vld_p1;
  logic [DATA_W-1:0] pc_p1;
  logic [DATA_W-1:0] rd1_p1;
  logic [DATA_W-1:0] rd2_p1;
  logic [DATA_W-1:0] imm_p1;
  logic [4:0]        rs_p1;
  logic [4:0]        rt_p1;
  logic [4:0]        writereg_p1;
  logic [2:0]        aluop_p1;
  logic              alusrc_p1;
  logic              regwrite_p1;
  logic              memtoreg_p1;
  logic              memwrite_p1;
  logic              illegal_p1;

  logic [3:0]        dec;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  assign dec = decode_alu(bus.id_aluop, bus.id_funct);

  // ---- ID -> EX boundary: flush bubbles the control, stall holds everything
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1      <= 1'b0;
      pc_p1       <= '0;
      rd1_p1      <= '0;
      rd2_p1      <= '0;
      imm_p1      <= '0;
      rs_p1       <= '0;
      rt_p1       <= '0;
      writereg_p1 <= '0;
      aluop_p1    <= '0;
      alusrc_p1   <= 1'b0;
      regwrite_p1 <= 1'b0;
      memtoreg_p1 <= 1'b0;
      memwrite_p1 <= 1'b0;
      illegal_p1  <= 1'b0;
    end else if (bus.flush) begin
      vld_p1      <= 1'b0;
      regwrite_p1 <= 1'b0;
      memtoreg_p1 <= 1'b0;
      memwrite_p1 <= 1'b0;
      illegal_p1  <= 1'b0;
    end else if (!bus.stall) begin
      vld_p1      <= bus.id_valid;
      pc_p1       <= bus.id_pc;
      rd1_p1      <= bus.id_rd1;
      rd2_p1      <= bus.id_rd2;
      imm_p1      <= bus.id_imm;
      rs_p1       <= bus.id_rs;
      rt_p1       <= bus.id_rt;
      writereg_p1 <= bus.id_writereg;
      aluop_p1    <= dec[2:0];
      alusrc_p1   <= bus.id_alusrc;
      regwrite_p1 <= bus.id_valid & bus.id_regwrite;
      memtoreg_p1 <= bus.id_valid & bus.id_memtoreg;
      memwrite_p1 <= bus.id_valid & bus.id_memwrite;
      illegal_p1  <= bus.id_valid & dec[3];
    end
  end

  // ---- EX operand selection: forwarding follows the live MEM/WB sources
  always_comb begin
    fwd_rs = forward(rs_p1, rd1_p1, bus.mem_regwrite, bus.mem_writereg,
                     bus.mem_result, bus.wb_regwrite, bus.wb_writereg,
                     bus.wb_result);
    fwd_rt = forward(rt_p1, rd2_p1, bus.mem_regwrite, bus.mem_writereg,
                     bus.mem_result, bus.wb_regwrite, bus.wb_writereg,
                     bus.wb_result);
  end

  assign bus.ex_valid     = vld_p1;
  assign bus.ex_pc        = pc_p1;
  assign bus.alu_num1     = fwd_rs;
  assign bus.alu_num2     = alusrc_p1 ? imm_p1 : fwd_rt;
  assign bus.alu_op       = aluop_p1;
  assign bus.ex_storedata = fwd_rt;
  assign bus.ex_writereg  = writereg_p1;
  assign bus.ex_regwrite  = regwrite_p1;
  assign bus.ex_memtoreg  = memtoreg_p1;
  assign bus.ex_memwrite  = memwrite_p1;
  assign bus.ex_illegal   = illegal_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized
// run scored against a behavioural model of the ID/EX register.
module tb_id_ex_stage;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_fail;

  id_ex_stage_if #(.DATA_W(32)) b ();

  id_ex_stage #(.DATA_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of what the EX stage currently holds
  logic        m_valid, m_known, m_alusrc, m_rw, m_mtr, m_mw, m_ill;
  logic [31:0] m_pc, m_rd1, m_rd2, m_imm;
  logic [4:0]  m_rs, m_rt, m_wr;
  logic [2:0]  m_op;

  // Table of supported R-type functions and their ALU codes
  logic [5:0] rfunct [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] rop    [5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

  function automatic logic [3:0] exp_decode(input logic [1:0] aluop, input logic [5:0] funct);
    if (aluop == 2'b00) return 4'b0010;
    if (aluop == 2'b01) return 4'b0110;
    if (aluop == 2'b11) return 4'b0001;
    for (int i = 0; i < 5; i++)
      if (rfunct[i] == funct) return {1'b0, rop[i]};
    return 4'b1010;
  endfunction

  function automatic logic [31:0] exp_fwd(input logic [4:0] r, input logic [31:0] regval);
    if (r == 5'd0) return regval;
    if (b.mem_regwrite && b.mem_writereg == r) return b.mem_result;
    if (b.wb_regwrite && b.wb_writereg == r) return b.wb_result;
    return regval;
  endfunction

  function automatic void model_clear();
    m_valid = 0; m_known = 1; m_alusrc = 0; m_rw = 0; m_mtr = 0; m_mw = 0; m_ill = 0;
    m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_rs = 0; m_rt = 0; m_wr = 0; m_op = 0;
  endfunction

  // Update the model from the inputs present just before the clock edge
  function automatic void model_capture();
    logic [3:0] d;
    if (b.flush) begin
      m_valid = 0; m_rw = 0; m_mw = 0; m_mtr = 0; m_ill = 0; m_known = 0;
    end else if (!b.stall) begin
      d = exp_decode(b.id_aluop, b.id_funct);
      m_known = 1;
      m_valid = b.id_valid;
      m_pc = b.id_pc; m_rd1 = b.id_rd1; m_rd2 = b.id_rd2; m_imm = b.id_imm;
      m_rs = b.id_rs; m_rt = b.id_rt; m_wr = b.id_writereg;
      m_op = d[2:0]; m_alusrc = b.id_alusrc;
      m_rw  = b.id_valid && b.id_regwrite;
      m_mtr = b.id_valid && b.id_memtoreg;
      m_mw  = b.id_valid && b.id_memwrite;
      m_ill = b.id_valid && d[3];
    end
  endfunction

  task automatic step();
    model_capture();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [31:0] pc, input logic [31:0] rd1,
                           input logic [31:0] rd2, input logic [31:0] imm, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] wr, input logic [1:0] aluop,
                           input logic [5:0] funct, input logic alusrc, input logic rw,
                           input logic mtr, input logic mw);
    b.id_valid = v; b.id_pc = pc; b.id_rd1 = rd1; b.id_rd2 = rd2; b.id_imm = imm;
    b.id_rs = rs; b.id_rt = rt; b.id_writereg = wr; b.id_aluop = aluop; b.id_funct = funct;
    b.id_alusrc = alusrc; b.id_regwrite = rw; b.id_memtoreg = mtr; b.id_memwrite = mw;
  endtask

  task automatic clear_fwd();
    b.mem_regwrite = 0; b.mem_writereg = 0; b.mem_result = 0;
    b.wb_regwrite = 0; b.wb_writereg = 0; b.wb_result = 0;
  endtask

  task automatic test_reset();
    set_instr(1, 32'h1234, 32'hA, 32'hB, 32'hC, 5'd3, 5'd4, 5'd9, 2'b10, 6'b101010, 0, 1, 1, 1);
    step();
    n_cmp++;
    if (b.ex_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid got=%0b want=1", b.ex_valid); end
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if (b.ex_valid !== 1'b0 || b.alu_op !== 3'b000 || b.ex_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state valid=%0b op=%b pc=%h want 0/000/0", b.ex_valid, b.alu_op, b.ex_pc);
    end
    n_cmp++;
    if ({b.ex_regwrite, b.ex_memtoreg, b.ex_memwrite, b.ex_illegal} !== 4'b0000 ||
        b.alu_num1 !== 32'h0 || b.ex_writereg !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl ctrl=%b num1=%h wr=%0d want 0", {b.ex_regwrite, b.ex_memtoreg,
               b.ex_memwrite, b.ex_illegal}, b.alu_num1, b.ex_writereg);
    end
    model_clear();
    #2 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_decode();
    logic [5:0] f [3] = '{6'b101010, 6'b100100, 6'b000000};
    logic [2:0] o [3] = '{3'b111, 3'b000, 3'b010};
    logic       il [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      set_instr(1, 32'h40 + 4*i, 0, 0, 0, 5'd1, 5'd2, 5'd3, 2'b10, f[i], 0, 1, 0, 0);
      step();
      n_cmp++;
      if (b.alu_op !== o[i] || b.ex_illegal !== il[i]) begin
        n_fail++;
        $display("FAIL decode_%0d op=%b ill=%0b want op=%b ill=%0b", i, b.alu_op, b.ex_illegal, o[i], il[i]);
      end
    end
  endtask

  task automatic test_fwd_priority();
    set_instr(1, 32'h200, 32'hAAAA, 32'hBBBB, 0, 5'd5, 5'd6, 5'd7, 2'b00, 0, 0, 1, 0, 0);
    step();
    b.mem_regwrite = 1; b.mem_writereg = 5; b.mem_result = 32'h11;
    b.wb_regwrite = 1;  b.wb_writereg = 5;  b.wb_result = 32'h22;
    #1;
    n_cmp++;
    if (b.alu_num1 !== 32'h11) begin n_fail++; $display("FAIL fwd_mem_wins got=%h want=00000011", b.alu_num1); end
    b.mem_regwrite = 0;
    #1;
    n_cmp++;
    if (b.alu_num1 !== 32'h22) begin n_fail++; $display("FAIL fwd_wb got=%h want=00000022", b.alu_num1); end
    b.wb_regwrite = 0;
    #1;
    n_cmp++;
    if (b.alu_num1 !== 32'hAAAA) begin n_fail++; $display("FAIL fwd_none got=%h want=0000aaaa", b.alu_num1); end
    clear_fwd();
  endtask

  task automatic test_zero_guard();
    set_instr(1, 32'h300, 32'h1, 32'h5555, 32'h77, 5'd0, 5'd0, 5'd8, 2'b00, 0, 0, 1, 0, 0);
    step();
    b.mem_regwrite = 1; b.mem_writereg = 0; b.mem_result = 32'hFFFF_FFFF;
    b.wb_regwrite = 1;  b.wb_writereg = 0;  b.wb_result = 32'hEEEE_EEEE;
    #1;
    n_cmp++;
    if (b.alu_num2 !== 32'h5555 || b.ex_storedata !== 32'h5555) begin
      n_fail++;
      $display("FAIL zero_guard num2=%h store=%h want=00005555", b.alu_num2, b.ex_storedata);
    end
    clear_fwd();
  endtask

  task automatic test_stall();
    set_instr(1, 32'h100, 32'h1, 32'h2, 0, 5'd7, 5'd8, 5'd9, 2'b01, 0, 0, 1, 0, 0);
    step();
    b.stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_instr(1, 32'h900 + i, $urandom, $urandom, $urandom, 5'd1, 5'd2, 5'd3, 2'b11, 0, 1, 0, 1, 1);
      step();
      b.wb_regwrite = 1; b.wb_writereg = 7; b.wb_result = 32'h5000 + i;
      #1;
      n_cmp++;
      if (b.ex_pc !== 32'h100 || b.alu_op !== 3'b110) begin
        n_fail++;
        $display("FAIL stall_hold_%0d pc=%h op=%b want pc=00000100 op=110", i, b.ex_pc, b.alu_op);
      end
      n_cmp++;
      if (b.alu_num1 !== 32'h5000 + i) begin
        n_fail++;
        $display("FAIL stall_fwd_%0d got=%h want=%h", i, b.alu_num1, 32'h5000 + i);
      end
    end
    b.stall = 0;
    clear_fwd();
  endtask

  task automatic test_flush();
    set_instr(1, 32'h500, 32'h10, 32'hCAFE, 32'h8, 5'd2, 5'd3, 5'd0, 2'b00, 0, 1, 0, 0, 1);
    step();
    n_cmp++;
    if (b.ex_valid !== 1'b1 || b.ex_memwrite !== 1'b1 || b.alu_num2 !== 32'h8) begin
      n_fail++;
      $display("FAIL sw_capture valid=%0b mw=%0b num2=%h want 1/1/00000008", b.ex_valid, b.ex_memwrite, b.alu_num2);
    end
    b.flush = 1; b.stall = 1;
    step();
    b.flush = 0; b.stall = 0;
    n_cmp++;
    if (b.ex_valid !== 1'b0 || b.ex_memwrite !== 1'b0 || b.ex_regwrite !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_bubble valid=%0b mw=%0b rw=%0b want 0/0/0", b.ex_valid, b.ex_memwrite, b.ex_regwrite);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int i = 0; i < 300; i++) begin
      set_instr($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom, $urandom,
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
                2'($urandom), ($urandom_range(0, 3) == 0) ? 6'($urandom) : rfunct[$urandom_range(0, 4)],
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      b.stall = ($urandom_range(0, 4) == 0);
      b.flush = ($urandom_range(0, 6) == 0);
      step();
      b.mem_regwrite = 1'($urandom); b.mem_writereg = 5'($urandom_range(0, 3)); b.mem_result = $urandom;
      b.wb_regwrite  = 1'($urandom); b.wb_writereg  = 5'($urandom_range(0, 3)); b.wb_result  = $urandom;
      #1;
      n_cmp++;
      if ({b.ex_valid, b.ex_regwrite, b.ex_memtoreg, b.ex_memwrite, b.ex_illegal} !==
          {m_valid, m_rw, m_mtr, m_mw, m_ill}) begin
        n_fail++;
        $display("FAIL rand_ctrl_%0d got=%b want=%b", i, {b.ex_valid, b.ex_regwrite, b.ex_memtoreg,
                 b.ex_memwrite, b.ex_illegal}, {m_valid, m_rw, m_mtr, m_mw, m_ill});
      end
      if (m_known) begin
        e1 = exp_fwd(m_rs, m_rd1);
        e2 = exp_fwd(m_rt, m_rd2);
        n_cmp++;
        if (b.ex_pc !== m_pc || b.alu_op !== m_op || b.ex_writereg !== m_wr) begin
          n_fail++;
          $display("FAIL rand_fields_%0d pc=%h op=%b wr=%0d want pc=%h op=%b wr=%0d", i,
                   b.ex_pc, b.alu_op, b.ex_writereg, m_pc, m_op, m_wr);
        end
        n_cmp++;
        if (b.alu_num1 !== e1 || b.ex_storedata !== e2 ||
            b.alu_num2 !== (m_alusrc ? m_imm : e2)) begin
          n_fail++;
          $display("FAIL rand_operands_%0d n1=%h n2=%h st=%h want n1=%h n2=%h st=%h", i,
                   b.alu_num1, b.alu_num2, b.ex_storedata, e1, (m_alusrc ? m_imm : e2), e2);
        end
      end
    end
    b.stall = 0; b.flush = 0;
    clear_fwd();
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    resetn = 1'b0;
    b.stall = 0; b.flush = 0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    clear_fwd();
    model_clear();
    #12 resetn = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_decode();
    test_fwd_priority();
    test_zero_guard();
    test_stall();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the five-stage MIPS core. It captures decoded operands and control from the decode stage and derives the 3-bit ALU operation code from `aluop`/`funct`. It resolves MEM/WB data forwarding and drives the EX-stage ALU operand and op inputs directly. Stall and flush inputs come from the hazard unit; the registered control fields feed the EX/MEM register.

## Interface
- `clk` in 1: rising-edge clock
- `resetn` in 1: asynchronous, active-low reset
- `stall` in 1: hold all ID/EX registers
- `flush` in 1: insert bubble (clear `ex_valid` and control)
- `id_valid` in 1: decode stage holds a valid instruction
- `id_pc` in 32: instruction PC
- `id_rd1`, `id_rd2` in 32: register-file read data (rs, rt)
- `id_imm` in 32: extended immediate
- `id_rs`, `id_rt` in 5: source register numbers
- `id_writereg` in 5: destination register number
- `id_aluop` in 2: 00 add, 01 sub, 10 R-type (use funct), 11 or
- `id_funct` in 6: instruction funct field
- `id_alusrc` in 1: 1 = operand B is immediate
- `id_regwrite`, `id_memtoreg`, `id_memwrite` in 1: control
- `mem_regwrite` in 1, `mem_writereg` in 5, `mem_result` in 32: MEM-stage forward source
- `wb_regwrite` in 1, `wb_writereg` in 5, `wb_result` in 32: WB-stage forward source
- `ex_valid` out 1: EX stage holds a valid instruction
- `ex_pc` out 32: registered PC
- `alu_num1`, `alu_num2` out 32: ALU operands
- `alu_op` out 3: ALU op (000 and, 001 or, 010 add, 110 sub, 111 slt)
- `ex_storedata` out 32: forwarded rt value for stores
- `ex_writereg` out 5, `ex_regwrite`, `ex_memtoreg`, `ex_memwrite` out 1: registered control
- `ex_illegal` out 1: the R-type funct was unsupported

## Operation
- Capture on the clock edge, in priority order:
  - If `flush`: clear `ex_valid`, `ex_regwrite`, `ex_memwrite`, `ex_memtoreg` and `ex_illegal`. Other fields are don't-care.
  - Else if `stall`: hold every register.
  - Else: load all `id_*` fields. `ex_valid` <= `id_valid`. When `id_valid`=0, the control bits load as 0.
- ALU op decode is done at capture and stored as a registered 3-bit field:
  - aluop 00 gives 010; aluop 01 gives 110; aluop 11 gives 001.
  - aluop 10 with funct 100000 gives 010; 100010 gives 110; 100100 gives 000; 100101 gives 001; 101010 gives 111.
  - Any other funct under aluop 10 gives 010 with `ex_illegal`=1.
- Forwarding is combinational from the registered rs/rt values, applied per operand:
  - If `mem_regwrite`, `mem_writereg`≠0 and `mem_writereg`==reg, use `mem_result`.
  - Else if `wb_regwrite`, `wb_writereg`≠0 and `wb_writereg`==reg, use `wb_result`.
  - Else use the registered rd1/rd2.
  - MEM always wins over WB. Register 0 is never forwarded.
- `alu_num1` = forwarded rs value.
- `ex_storedata` = forwarded rt value.
- `alu_num2` = registered imm when alusrc=1, otherwise the forwarded rt value.
- Load-use hazards are not detected here. The hazard unit asserts `stall` upstream and `flush` here.

## Timing
- Reset (async, `resetn`=0) clears every register to 0. All registered outputs read 0, `alu_op`=000 and `ex_valid`=0. Reset takes effect immediately, mid-instruction.
- Latency: one cycle from `id_*` to `ex_*`.
- `alu_num1`, `alu_num2` and `ex_storedata` are valid in the same cycle that the forward sources change; there are no extra cycles.
- When `flush` and `stall` are asserted together, flush wins: the result is a bubble.
- A held (stalled) instruction re-evaluates forwarding every cycle, so it picks up new MEM/WB results.

## Test plan
- Reset: assert `resetn`=0 mid-stream → `ex_valid`=0, `alu_op`=000, all control 0 and `ex_pc`=0 immediately, with no clock edge required.
- Decode: aluop=10 with funct 101010, then 100100, then 000000 → `alu_op` reads 111, then 000, then 010 with `ex_illegal`=1, one cycle after each.
- Forwarding priority: rs=5, `mem_writereg`=5 with `mem_result`=0x11, and `wb_writereg`=5 with `wb_result`=0x22, both regwrite=1 → `alu_num1`=0x11. Drop `mem_regwrite` → `alu_num1`=0x22.
- $0 guard: rt=0, `mem_writereg`=0, `mem_regwrite`=1, `mem_result`=0xFFFF_FFFF, alusrc=0 → `alu_num2` equals the registered rd2.
- Stall: capture PC 0x100, then hold `stall`=1 for 3 cycles while the `id_*` inputs change → `ex_pc` stays 0x100. Change `wb_result` during the stall → the operand follows it.
- Flush: a valid sw is captured; assert `flush`+`stall` → next cycle `ex_valid`=0 and `ex_memwrite`=0.
